// File: rtl/control_unit.sv
// rtl/control_unit.sv - Sim-AC multicycle sequencer: fetch/decode/execute strobes, retire counter, halt
// Optional single-step gating is built when CU_SINGLE_STEP_EN is defined.
module control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       op_i,
  input  logic             mem_ready_i,
`ifdef CU_SINGLE_STEP_EN
  input  logic             step_i,
`endif
  output logic             mar_load_o,
  output logic             mar_src_o,
  output logic             mem_rd_o,
  output logic             mem_wr_o,
  output logic             ir_load_o,
  output logic             pc_inc_o,
  output logic             ctrl_jmp_o,
  output logic             acc_load_o,
  output logic             alu_add_o,
  output logic             flags_load_o,
  output logic             halt_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_STA = 3'b011;
  localparam logic [2:0] OP_JMP = 3'b100;
  localparam logic [2:0] OP_JZ  = 3'b101;
  localparam logic [2:0] OP_JC  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH_A,
    S_FETCH_M,
    S_DECODE,
    S_EXEC_MEM,
    S_BRANCH,
    S_HALT
`ifdef CU_SINGLE_STEP_EN
    , S_WAIT_STEP
`endif
  } state_t;

  // Where every non-HLT instruction goes once it retires.
`ifdef CU_SINGLE_STEP_EN
  localparam state_t S_AFTER_RETIRE = S_WAIT_STEP;
`else
  localparam state_t S_AFTER_RETIRE = S_FETCH_A;
`endif

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;
  logic             is_mem_op;

  assign is_mem_op = (op_i == OP_LDA) || (op_i == OP_ADD) || (op_i == OP_STA);

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_DECODE:   retire = (op_i == OP_NOP) || (op_i == OP_HLT);
      S_BRANCH:   retire = 1'b1;
      S_EXEC_MEM: retire = mem_ready_i;
      default:    retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH_A;
      cnt_q   <= '0;
    end else begin
      if (retire && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      case (state_q)
        S_FETCH_A: state_q <= S_FETCH_M;
        S_FETCH_M: if (mem_ready_i) state_q <= S_DECODE;
        S_DECODE: begin
          case (op_i)
            OP_NOP:                state_q <= S_AFTER_RETIRE;
            OP_HLT:                state_q <= S_HALT;
            OP_JMP, OP_JZ, OP_JC:  state_q <= S_BRANCH;
            default:               state_q <= S_EXEC_MEM;
          endcase
        end
        S_BRANCH:   state_q <= S_AFTER_RETIRE;
        S_EXEC_MEM: if (mem_ready_i) state_q <= S_AFTER_RETIRE;
        S_HALT:     state_q <= S_HALT;
`ifdef CU_SINGLE_STEP_EN
        S_WAIT_STEP: if (step_i) state_q <= S_FETCH_A;
`endif
        default:    state_q <= S_FETCH_A;
      endcase
    end
  end

  // Strobes are a pure decode so memory handshakes complete in the ready cycle.
  always_comb begin
    mar_load_o   = 1'b0;
    mar_src_o    = 1'b0;
    mem_rd_o     = 1'b0;
    mem_wr_o     = 1'b0;
    ir_load_o    = 1'b0;
    pc_inc_o     = 1'b0;
    ctrl_jmp_o   = 1'b0;
    acc_load_o   = 1'b0;
    alu_add_o    = 1'b0;
    flags_load_o = 1'b0;
    halt_o       = 1'b0;
    if (!rst_i) begin
      case (state_q)
        S_FETCH_A: mar_load_o = 1'b1;
        S_FETCH_M: begin
          mem_rd_o = 1'b1;
          if (mem_ready_i) begin
            ir_load_o = 1'b1;
            pc_inc_o  = 1'b1;
          end
        end
        S_DECODE: begin
          if (is_mem_op) begin
            mar_load_o = 1'b1;
            mar_src_o  = 1'b1;
          end
        end
        S_EXEC_MEM: begin
          if (op_i == OP_STA) begin
            mem_wr_o = 1'b1;
          end else begin
            mem_rd_o = 1'b1;
            if (mem_ready_i) begin
              acc_load_o   = 1'b1;
              flags_load_o = 1'b1;
              alu_add_o    = (op_i == OP_ADD);
            end
          end
        end
        S_BRANCH: ctrl_jmp_o = 1'b1;
        S_HALT:   halt_o     = 1'b1;
        default:  ;
      endcase
    end
  end

  assign instr_cnt_o = rst_i ? '0 : cnt_q;

endmodule
